// File: rtl/jk_excite_seq_if.sv
// Load channel of the JK excitation sequencer.
//   load_valid  master -> slave  pattern/repeat_en are valid
//   load_ready  slave -> master  sequencer can accept a pattern
//   pattern     master -> slave  target q sequence, bit 0 applied first
//   repeat_en   master -> slave  loop the pattern until reset
interface jk_excite_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic             repeat_en;

  modport master (
    output load_valid,
    output pattern,
    output repeat_en,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  pattern,
    input  repeat_en,
    output load_ready
  );
endinterface

// File: rtl/jk_excite_seq.sv
// Excitation sequencer for a downstream negedge-clocked JK flip-flop.
// Accepts a WIDTH-bit target pattern on the load channel and drives j/k on
// the rising edge so the flip-flop steps through the pattern LSB first,
// while checking the fed-back q against each target bit.
//   clk      rising-edge clock shared with the flip-flop
//   reset    synchronous, active-low
//   ld       load channel (load_valid/load_ready/pattern/repeat_en)
//   q_fb     q of the driven flip-flop
//   j, k     registered excitation
//   busy     high while a pattern is running
//   done     one-cycle pulse at the end of a non-repeating pass
//   err      sticky mismatch flag, cleared at accept
//   err_idx  index of the first mismatching bit
module jk_excite_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          TOGGLE_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  jk_excite_seq_if.slave             ld,
  input  logic                       q_fb,
  output logic                       j,
  output logic                       k,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(WIDTH)-1:0]   err_idx
);

  localparam int unsigned IW   = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] pat, pat_n;
  logic             rep, rep_n;
  logic             rdy;
  logic             j_n, k_n, done_n, err_n;
  logic [IW-1:0]    err_idx_n;

  // {j,k} needed to move q to target t
  function automatic logic [1:0] excite(input logic t, input logic q);
    if (q == t)       return 2'b00;
    else if (TOGGLE_MODE) return 2'b11;
    else              return {t, ~t};
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pat_n     = pat;
    rep_n     = rep;
    j_n       = 1'b0;
    k_n       = 1'b0;
    done_n    = 1'b0;
    err_n     = err;
    err_idx_n = err_idx;
    case (state)
      IDLE: begin
        if (ld.load_valid && rdy) begin
          pat_n      = ld.pattern;
          rep_n      = ld.repeat_en;
          err_n      = 1'b0;
          err_idx_n  = '0;
          idx_n      = '0;
          {j_n, k_n} = excite(ld.pattern[0], q_fb);
          state_n    = RUN;
        end
      end
      RUN: begin
        if ((q_fb != pat[idx]) && !err) begin
          err_n     = 1'b1;
          err_idx_n = idx;
        end
        if (idx != LAST) begin
          idx_n      = idx + IW'(1);
          {j_n, k_n} = excite(pat[idx_n], q_fb);
        end else if (rep) begin
          idx_n      = '0;
          {j_n, k_n} = excite(pat[0], q_fb);
        end else begin
          idx_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      pat     <= '0;
      rep     <= 1'b0;
      rdy     <= 1'b0;
      j       <= 1'b0;
      k       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pat     <= pat_n;
      rep     <= rep_n;
      // Registered so ready stays low until the first edge out of reset and
      // for the hold cycle after done is already covered by state.
      rdy     <= (state_n == IDLE);
      j       <= j_n;
      k       <= k_n;
      done    <= done_n;
      err     <= err_n;
      err_idx <= err_idx_n;
    end
  end

  assign ld.load_ready = rdy;
  assign busy          = (state == RUN);

endmodule
